// File: rtl/s_mem_pkg.sv
// s_mem_pkg: shared constants and state encoding for the S-memory reader-side checker.
//   ADDR_W / DATA_W : memory address and data width (DATA_W must equal ADDR_W).
//   DEPTH           : number of memory words, 2**ADDR_W.
//   chk_state_t     : sweep FSM states.
package s_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } chk_state_t;
endpackage

// File: rtl/s_mem_checker_perm_tracker.sv
// perm_tracker: "seen" bitmap with one bit per possible byte value.
//   clk, rst_n : clock, asynchronous active-low reset (clears the bitmap)
//   clr        : synchronous clear of the whole bitmap
//   chk        : test-and-set strobe for value idx
//   idx        : value being tested
//   dup        : combinational; 1 when chk is high and idx was already marked
module perm_tracker
  import s_mem_pkg::*;
#(
  parameter int IDX_W = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             chk,
  input  logic [IDX_W-1:0] idx,
  output logic             dup
);

  localparam int NBITS = 1 << IDX_W;

  logic [NBITS-1:0] seen;

  // The test reads the bit before this edge's set, so a duplicate is flagged
  // in the same cycle its second occurrence is presented.
  assign dup = chk & seen[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else if (clr) begin
      seen <= '0;
    end else if (chk) begin
      seen[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/s_mem_checker.sv
// s_mem_checker: sweeps all 2**ADDR_W addresses of the S memory through its read
// port and checks either identity (mem[i]==i) or permutation (no repeated value).
//   clk, rst_n     : clock, asynchronous active-low reset
//   en, mode       : start request (taken when rdy=1); mode 0=identity, 1=permutation
//   rdy            : idle, can accept en
//   addr, rddata   : read port (registered address, q valid the cycle after addr)
//   wren           : always 0
//   done, pass     : results valid / no mismatches
//   mismatch_cnt   : number of failing reads
//   first_bad_addr : address of the first failing read, 0 if none
module s_mem_checker
  import s_mem_pkg::*;
#(
  parameter int ADDR_W = s_mem_pkg::ADDR_W,
  parameter int DATA_W = s_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic              wren,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] first_bad_addr
);

  chk_state_t        state;
  logic              mode_q;

  logic              vld_p0;
  logic              last_p0;
  logic [ADDR_W-1:0] tag_p0;

  logic              vld_p1;
  logic              last_p1;
  logic [ADDR_W-1:0] tag_p1;
  logic [DATA_W-1:0] rd_p1;

  logic              start;
  logic              dup_p1;
  logic              fail_p1;
  logic [ADDR_W:0]   cnt_nxt;

  assign wren    = 1'b0;
  assign start   = (state == ST_IDLE) && en;
  assign fail_p1 = vld_p1 && (mode_q ? dup_p1 : (rd_p1 != tag_p1));
  assign cnt_nxt = mismatch_cnt + {{ADDR_W{1'b0}}, fail_p1};

  perm_tracker #(.IDX_W(DATA_W)) u_perm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .chk   (vld_p1),
    .idx   (rd_p1),
    .dup   (dup_p1)
  );

  // Data path: tag the issued address, then capture the memory q with its tag.
  always_ff @(posedge clk) begin
    // p0: address issued to memory this cycle
    tag_p0 <= addr;
    // p1: memory q for tag_p0, registered ahead of the compare
    tag_p1 <= tag_p0;
    rd_p1  <= rddata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mode_q         <= 1'b0;
      rdy            <= 1'b1;
      addr           <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_bad_addr <= '0;
      vld_p0         <= 1'b0;
      last_p0        <= 1'b0;
      vld_p1         <= 1'b0;
      last_p1        <= 1'b0;
    end else begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;

      // p2: compare and accumulate results
      if (fail_p1) begin
        mismatch_cnt <= cnt_nxt;
        if (mismatch_cnt == '0) begin
          first_bad_addr <= tag_p1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (en) begin
            mode_q         <= mode;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_bad_addr <= '0;
            addr           <= '0;
            rdy            <= 1'b0;
            state          <= ST_READ;
          end
        end
        ST_READ: begin
          vld_p0 <= 1'b1;
          if (addr == '1) begin
            last_p0 <= 1'b1;
            state   <= ST_DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Finish on the edge that evaluates the read of the last address.
          if (vld_p1 && last_p1) begin
            done  <= 1'b1;
            pass  <= (cnt_nxt == '0);
            rdy   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mem_checker.sv
module tb_s_mem_checker;
  import s_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        rdy;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic        wren;
  logic        done;
  logic        pass;
  logic [8:0]  mismatch_cnt;
  logic [7:0]  first_bad_addr;

  logic [7:0]  mem [256];
  logic [7:0]  addr_q;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // Memory with registered address and unregistered q.
  always @(posedge clk) addr_q <= addr;
  assign rddata = mem[addr_q];

  s_mem_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mode           (mode),
    .rdy            (rdy),
    .addr           (addr),
    .rddata         (rddata),
    .wren           (wren),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_bad_addr (first_bad_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the memory in address order applying the check rule.
  task automatic model(input bit m, output int cnt, output int first);
    bit seen [256];
    bit bad;
    cnt = 0;
    first = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bad = m ? seen[mem[i]] : (int'(mem[i]) != i);
      seen[mem[i]] = 1'b1;
      if (bad) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rdy"},   rdy, 1);
    check({tag, ".done"},  done, 0);
    check({tag, ".pass"},  pass, 0);
    check({tag, ".wren"},  wren, 0);
    check({tag, ".cnt"},   mismatch_cnt, 0);
    check({tag, ".first"}, first_bad_addr, 0);
    check({tag, ".addr"},  addr, 0);
  endtask

  // Start a sweep and watch it to completion. en_at >= 0 raises en at that
  // cycle and holds it until the sweep reports done.
  task automatic sweep(input string tag, input bit m, input int en_at);
    int cyc;
    int aerr;
    int ecnt;
    int efirst;
    @(negedge clk);
    mode = m;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check({tag, ".rdy_low"}, rdy, 0);
    aerr = (addr !== 8'd0) ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == en_at) en = 1'b1;
      mode = 1'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      if (cyc <= 255) begin
        if (int'(addr) != cyc) aerr++;
      end else if (addr !== 8'hff) begin
        aerr++;
      end
    end
    en = 1'b0;
    model(m, ecnt, efirst);
    check({tag, ".latency"}, cyc, 258);
    check({tag, ".addr_seq_errs"}, aerr, 0);
    check({tag, ".rdy"}, rdy, 1);
    check({tag, ".pass"}, pass, (ecnt == 0) ? 1 : 0);
    check({tag, ".cnt"}, mismatch_cnt, ecnt);
    check({tag, ".first"}, first_bad_addr, efirst);
    if (en_at >= 0) begin
      // en was high on the edge rdy returned; it must not have started a sweep.
      @(posedge clk);
      #1;
      check({tag, ".stay_idle_rdy"}, rdy, 1);
      check({tag, ".stay_idle_done"}, done, 1);
      check({tag, ".stay_idle_cnt"}, mismatch_cnt, ecnt);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int j;
    int k;
    int pat;
    logic [7:0] tmp;

    fill_identity();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity memory, both modes
    sweep("ident_m0", 1'b0, -1);
    sweep("ident_m1", 1'b1, -1);

    // Single corruption at address 37
    mem[37] = 8'h00;
    sweep("bad37_m0", 1'b0, -1);
    sweep("bad37_m1", 1'b1, -1);

    // Reversed permutation
    for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
    sweep("rev_m1", 1'b1, -1);
    sweep("rev_m0", 1'b0, -1);

    // en re-pulsed mid-sweep and held across the completion edge
    fill_identity();
    mem[200] = 8'h05;
    sweep("repulse", 1'b0, 100);

    // Randomized memories
    for (int t = 0; t < 8; t++) begin
      pat = $urandom_range(0, 2);
      if (pat == 0) begin
        fill_identity();
        for (int i = 255; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = mem[i];
          mem[i] = mem[j];
          mem[j] = tmp;
        end
      end else if (pat == 1) begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      end else begin
        fill_identity();
        k = $urandom_range(1, 6);
        for (int c = 0; c < k; c++) begin
          j = $urandom_range(0, 255);
          mem[j] = 8'($urandom);
        end
      end
      sweep($sformatf("rand%0d", t), 1'($urandom), -1);
    end

    // Reset in the middle of a sweep
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    mode = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("mid_reset.addr_before", addr, 120);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset.async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("mid_reset.hold");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_reset_m1", 1'b1, -1);
    sweep("after_reset_m0", 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
